// File: rtl/ct_spsram_pkg.sv
// ============================================================================
// ct_spsram_pkg : shared types and helpers for the ct_spsram init wrapper
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ct_spsram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } seq_state_e;

    // Widest write-enable group the parity helper accepts; callers zero-extend.
    localparam int unsigned PAR_GRP_MAX_W = 256;

    function automatic int unsigned group_width(input int unsigned data_w,
                                                input int unsigned we_w);
        return data_w / we_w;
    endfunction

    // Even parity: the stored bit makes the group plus parity XOR to zero.
    function automatic logic group_parity(input logic [PAR_GRP_MAX_W-1:0] grp);
        return ^grp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ct_spsram_init_seq.sv
// ============================================================================
// ct_spsram_init_seq : init/idle sequencer and init-vs-external access mux
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ct_spsram_init_seq
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 84,
    parameter int unsigned           WE_WIDTH   = 84,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_req_i,
    input  logic                  cen_i,
    input  logic                  gwen_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WE_WIDTH-1:0]   wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WE_WIDTH-1:0]   mem_gbe_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  rd_issue_o,
    output logic                  init_busy_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_i;
        mem_gbe_o   = '0;
        mem_wdata_o = wdata_i;
        init_busy_o = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_busy_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = cnt_q;
                mem_gbe_o   = '1;
                mem_wdata_o = INIT_VALUE;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A re-init request outranks any access presented in the same cycle.
                if (init_req_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (!cen_i) begin
                    mem_req_o = 1'b1;
                    mem_we_o  = ~gwen_i;
                    mem_gbe_o = gwen_i ? '0 : ~wen_i;
                end
            end
            default: ;
        endcase
    end

    assign rd_issue_o = mem_req_o & ~mem_we_o;

endmodule

`default_nettype wire

// File: rtl/tc_sram.sv
// ============================================================================
// tc_sram : single-port RAM, one-cycle read latency, bit-granular write enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module tc_sram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 84
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] be_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~be_i) | (wdata_i & be_i);
        end
    end

    // Read data holds until the next read so the wrapper can present it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (req_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ct_spsram_init_wrap.sv
// ============================================================================
// ct_spsram_init_wrap : parametrised SPSRAM with hardware init and 1/2-cycle read
//                       latency; optional group parity via CT_SPSRAM_PARITY_EN
// Revision            : 1.0
// ============================================================================
`default_nettype none

module ct_spsram_init_wrap
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_WIDTH  = 84,
    parameter int unsigned           WE_WIDTH    = 84,
    parameter int unsigned           OUT_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QVLD,
    input  logic                  init_req,
    output logic                  init_busy
`ifdef CT_SPSRAM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int unsigned GW = group_width(DATA_WIDTH, WE_WIDTH);
`ifdef CT_SPSRAM_PARITY_EN
    localparam int unsigned PW = WE_WIDTH;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned SW = DATA_WIDTH + PW;

    if (DATA_WIDTH % WE_WIDTH != 0) begin : g_bad_groups
        $error("ct_spsram_init_wrap: DATA_WIDTH must be a multiple of WE_WIDTH");
    end

    logic                  w_req;
    logic                  w_we;
    logic                  w_rd_issue;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WE_WIDTH-1:0]   w_gbe;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [SW-1:0]         w_store_wdata;
    logic [SW-1:0]         w_store_be;
    logic [SW-1:0]         w_rdata;
    logic                  qvld1_q;

    ct_spsram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_seq (
        .clk_i       (forever_cpuclk),
        .rst_ni      (cpurst_b),
        .init_req_i  (init_req),
        .cen_i       (CEN),
        .gwen_i      (GWEN),
        .addr_i      (A),
        .wen_i       (WEN),
        .wdata_i     (D),
        .mem_req_o   (w_req),
        .mem_we_o    (w_we),
        .mem_addr_o  (w_addr),
        .mem_gbe_o   (w_gbe),
        .mem_wdata_o (w_wdata),
        .rd_issue_o  (w_rd_issue),
        .init_busy_o (init_busy)
    );

    assign w_store_wdata[DATA_WIDTH-1:0] = w_wdata;

    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_grp
        assign w_store_be[g*GW +: GW] = {GW{w_gbe[g]}};
`ifdef CT_SPSRAM_PARITY_EN
        assign w_store_be[DATA_WIDTH+g]    = w_gbe[g];
        assign w_store_wdata[DATA_WIDTH+g] = group_parity(PAR_GRP_MAX_W'(w_wdata[g*GW +: GW]));
`endif
    end

    tc_sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (SW)
    ) u_sram (
        .clk_i   (forever_cpuclk),
        .rst_ni  (cpurst_b),
        .req_i   (w_req),
        .we_i    (w_we),
        .addr_i  (w_addr),
        .wdata_i (w_store_wdata),
        .be_i    (w_store_be),
        .rdata_o (w_rdata)
    );

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            qvld1_q <= 1'b0;
        end else begin
            qvld1_q <= w_rd_issue;
        end
    end

`ifdef CT_SPSRAM_PARITY_EN
    logic [WE_WIDTH-1:0] w_par_mis;
    logic                w_perr1;
    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_par_chk
        assign w_par_mis[g] = w_rdata[DATA_WIDTH+g]
                            ^ group_parity(PAR_GRP_MAX_W'(w_rdata[g*GW +: GW]));
    end
    assign w_perr1 = |w_par_mis;
`endif

    if (OUT_LATENCY == 1) begin : g_lat1
        assign Q    = w_rdata[DATA_WIDTH-1:0];
        assign QVLD = qvld1_q;
`ifdef CT_SPSRAM_PARITY_EN
        assign parity_err = qvld1_q & w_perr1;
`endif
    end else if (OUT_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q2_q;
        logic                  qvld2_q;
`ifdef CT_SPSRAM_PARITY_EN
        logic                  perr2_q;
`endif
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                q2_q    <= '0;
                qvld2_q <= 1'b0;
`ifdef CT_SPSRAM_PARITY_EN
                perr2_q <= 1'b0;
`endif
            end else begin
                qvld2_q <= qvld1_q;
`ifdef CT_SPSRAM_PARITY_EN
                perr2_q <= qvld1_q & w_perr1;
`endif
                if (qvld1_q) begin
                    q2_q <= w_rdata[DATA_WIDTH-1:0];
                end
            end
        end
        assign Q    = q2_q;
        assign QVLD = qvld2_q;
`ifdef CT_SPSRAM_PARITY_EN
        assign parity_err = perr2_q;
`endif
    end else begin : g_bad_latency
        $error("ct_spsram_init_wrap: OUT_LATENCY must be 1 or 2");
    end

endmodule

`default_nettype wire

// File: tb/tb_ct_spsram_init_wrap.sv
// ============================================================================
// tb_ct_spsram_init_wrap : drives a latency-1 and a latency-2 instance in lockstep
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_ct_spsram_init_wrap;

    localparam int AW    = 8;
    localparam int DW    = 84;
    localparam int WW    = 21;
    localparam int GW    = DW / WW;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT = 84'h1_2345_6789_ABCD_EF01_2345;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          cen      = 1'b1;
    logic          gwen     = 1'b1;
    logic          init_req = 1'b0;
    logic [AW-1:0] a        = '0;
    logic [WW-1:0] wen      = '1;
    logic [DW-1:0] d        = '0;

    logic [DW-1:0] q1, q2;
    logic          vld1, vld2, busy1, busy2;
`ifdef CT_SPSRAM_PARITY_EN
    logic          perr1, perr2;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ct_spsram_init_wrap #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_LATENCY(1), .INIT_VALUE(INIT)
    ) dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen),
        .D(d), .Q(q1), .QVLD(vld1), .init_req(init_req), .init_busy(busy1)
`ifdef CT_SPSRAM_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    ct_spsram_init_wrap #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_LATENCY(2), .INIT_VALUE(INIT)
    ) dut2 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen),
        .D(d), .Q(q2), .QVLD(vld2), .init_req(init_req), .init_busy(busy2)
`ifdef CT_SPSRAM_PARITY_EN
        , .parity_err(perr2)
`endif
    );

    task automatic chk_dw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: array contents, remaining-init bookkeeping and a list of
    // scheduled read completions keyed by the clock edge on which each appears.
    typedef struct {
        longint        due;
        logic [DW-1:0] dat;
        bit            pe;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_bad [DEPTH];
    rd_t           m_p1[$];
    rd_t           m_p2[$];
    bit            m_busy = 1'b1;
    int            m_icnt = 0;
    longint        m_cyc  = 0;
    logic [DW-1:0] e_q1 = '0, e_q2 = '0;
    bit            e_v1 = 1'b0, e_v2 = 1'b0, e_pe1 = 1'b0, e_pe2 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b1; m_icnt = 0;
            m_p1.delete(); m_p2.delete();
            e_q1 = '0; e_q2 = '0; e_v1 = 1'b0; e_v2 = 1'b0; e_pe1 = 1'b0; e_pe2 = 1'b0;
        end else begin
            m_cyc++;
            if (m_busy) begin
                m_mem[m_icnt] = INIT;
                m_bad[m_icnt] = 1'b0;
                m_icnt++;
                if (m_icnt == DEPTH) begin
                    m_busy = 1'b0;
                    m_icnt = 0;
                end
            end else if (init_req) begin
                m_busy = 1'b1;
                m_icnt = 0;
            end else if (!cen && !gwen) begin
                for (int g = 0; g < WW; g++)
                    if (!wen[g]) m_mem[a][g*GW +: GW] = d[g*GW +: GW];
                if (wen == '0) m_bad[a] = 1'b0;
            end else if (!cen) begin
                m_p1.push_back('{m_cyc,     m_mem[a], m_bad[a]});
                m_p2.push_back('{m_cyc + 1, m_mem[a], m_bad[a]});
            end
            e_v1 = 1'b0; e_pe1 = 1'b0;
            if (m_p1.size() > 0 && m_p1[0].due == m_cyc) begin
                e_q1 = m_p1[0].dat; e_v1 = 1'b1; e_pe1 = m_p1[0].pe; void'(m_p1.pop_front());
            end
            e_v2 = 1'b0; e_pe2 = 1'b0;
            if (m_p2.size() > 0 && m_p2[0].due == m_cyc) begin
                e_q2 = m_p2[0].dat; e_v2 = 1'b1; e_pe2 = m_p2[0].pe; void'(m_p2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk_bit("init_busy L1", busy1, m_busy);
        chk_bit("init_busy L2", busy2, m_busy);
        chk_bit("QVLD L1", vld1, e_v1);
        chk_bit("QVLD L2", vld2, e_v2);
        chk_dw("Q L1", q1, e_q1);
        chk_dw("Q L2", q2, e_q2);
`ifdef CT_SPSRAM_PARITY_EN
        chk_bit("parity_err L1", perr1, e_pe1);
        chk_bit("parity_err L2", perr2, e_pe2);
`endif
    end

    task automatic idle();
        cen = 1'b1; gwen = 1'b1; wen = '1; init_req = 1'b0;
    endtask

    task automatic drive_rd(input logic [AW-1:0] ad);
        cen = 1'b0; gwen = 1'b1; wen = '1; a = ad; init_req = 1'b0;
    endtask

    task automatic drive_wr(input logic [AW-1:0] ad, input logic [DW-1:0] dd, input logic [WW-1:0] we);
        cen = 1'b0; gwen = 1'b0; wen = we; a = ad; d = dd; init_req = 1'b0;
    endtask

    // Counts busy cycles from the current falling edge; optionally pokes the
    // array while the sequencer owns it.
    task automatic wait_init(input bit junk);
        int cnt = 0;
        int vcnt = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy1) break;
            cnt++;
            if (junk && (vld1 || vld2)) vcnt++;
            if (junk && cnt == 10)      drive_wr(3, {4'hA, {10{8'hAB}}}, '0);
            else if (junk && cnt == 11) drive_rd(3);
            else                        idle();
            @(negedge clk);
        end
        idle();
        chk_int("init_busy length", cnt, 256);
        if (junk) chk_int("QVLD during init", vcnt, 0);
    endtask

    task automatic rd_pin(input logic [AW-1:0] ad, input logic [DW-1:0] exp, input string nm);
        drive_rd(ad);
        @(negedge clk);
        idle();
        chk_bit({nm, " QVLD L1"}, vld1, 1'b1);
        chk_dw({nm, " Q L1"}, q1, exp);
        chk_bit({nm, " QVLD L2 early"}, vld2, 1'b0);
        @(negedge clk);
        chk_bit({nm, " QVLD L2"}, vld2, 1'b1);
        chk_dw({nm, " Q L2"}, q2, exp);
        chk_bit({nm, " QVLD L1 single"}, vld1, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int first;
        int cnt;
        idle();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("reset init_busy", busy1, 1'b1);
        chk_dw("reset Q L2", q2, '0);
        chk_bit("reset QVLD L2", vld2, 1'b0);
        rst_n = 1'b1;
        wait_init(1'b1);

        rd_pin(0,   INIT, "T1 a0");
        rd_pin(127, INIT, "T1 a127");
        rd_pin(255, INIT, "T1 a255");
        rd_pin(3,   INIT, "T3 a3");

        drive_wr(5, '1, 21'h0AAAAA);
        @(negedge clk);
        drive_wr(6, '0, '1);
        @(negedge clk);
        idle();
        @(negedge clk);
        rd_pin(5, 84'hF_2F4F_6F8F_AFCF_EF0F_2F4F, "T2 a5");
        rd_pin(6, INIT, "T2 noop a6");

        for (int i = 0; i < 10; i++) begin
            drive_wr(AW'(i), {21{4'(i + 1)}}, '0);
            @(negedge clk);
        end
        first = -1;
        cnt   = 0;
        for (int j = 0; j < 14; j++) begin
            if (vld2) begin
                cnt++;
                if (first < 0) first = j;
            end
            if (j < 10) drive_rd(AW'(j));
            else        idle();
            @(negedge clk);
        end
        chk_int("T4 QVLD L2 count", cnt, 10);
        chk_int("T4 QVLD L2 first cycle", first, 2);
        chk_dw("T4 Q L2 hold", q2, {21{4'hA}});

        drive_rd(9);
        @(negedge clk);
        drive_wr(7, '0, '0);
        init_req = 1'b1;
        @(negedge clk);
        idle();
        wait_init(1'b0);
        rd_pin(7, INIT, "T5 a7");
        rd_pin(5, INIT, "T5 a5 cleared");

        init_req = 1'b1;
        @(negedge clk);
        idle();
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_bit("T5 mid-init reset busy", busy1, 1'b1);
        rst_n = 1'b1;
        wait_init(1'b0);
        rd_pin(0, INIT, "T5 post-reset a0");

        drive_rd(8);
        @(negedge clk);
        idle();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_bit("T5 in-flight read dropped", vld2, 1'b0);
        chk_dw("T5 in-flight Q cleared", q2, '0);
        rst_n = 1'b1;
        wait_init(1'b0);

`ifdef CT_SPSRAM_PARITY_EN
        dut1.u_sram.mem_q[9][0] = ~dut1.u_sram.mem_q[9][0];
        dut2.u_sram.mem_q[9][0] = ~dut2.u_sram.mem_q[9][0];
        m_mem[9][0] = ~m_mem[9][0];
        m_bad[9]    = 1'b1;
        drive_rd(9);
        @(negedge clk);
        drive_rd(8);
        chk_bit("T6 parity_err L1 a9", perr1, 1'b1);
        chk_dw("T6 Q L1 a9 unmodified", q1, INIT ^ 84'h1);
        @(negedge clk);
        idle();
        chk_bit("T6 parity_err L2 a9", perr2, 1'b1);
        chk_bit("T6 parity_err L1 a8", perr1, 1'b0);
        @(negedge clk);
        chk_bit("T6 parity_err L2 a8", perr2, 1'b0);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ct_spsram_init_wrap.md
Name: ct_spsram_init_wrap

Overview:
Parametrised single-port SRAM wrapper, the successor to the fixed-geometry ct_spsram_* macros used in the MMU and caches. It keeps the active-low CEN/GWEN/WEN access interface. It adds:
- a hardware init sequencer that clears or presets every word after reset or on request;
- grouped byte/field write enables;
- a selectable 1- or 2-cycle read latency with a valid strobe.

TLB and tag arrays instantiate it in place of per-size wrappers and software flush loops.

Parameters:
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 84, word width.
WE_WIDTH, 84, write-enable groups; DATA_WIDTH % WE_WIDTH == 0; group g covers bits [g*GW +: GW], where GW = DATA_WIDTH/WE_WIDTH.
OUT_LATENCY, 1, read latency in cycles; legal values 1 or 2; any other value is an elaboration error.
INIT_VALUE, '0, DATA_WIDTH word written to every address during init.

Ports:
forever_cpuclk  in  1  clock; all state on rising edge.
cpurst_b  in  1  asynchronous active-low reset.
A  in  ADDR_WIDTH  access address.
CEN  in  1  chip enable, active low.
GWEN  in  1  global write enable, active low; 1 = read.
WEN  in  WE_WIDTH  per-group write enable, active low.
D  in  DATA_WIDTH  write data.
Q  out  DATA_WIDTH  read data, held until the next read completes.
QVLD  out  1  one-cycle pulse when Q carries new read data.
init_req  in  1  pulse; starts a full-array re-init.
init_busy  out  1  high while the sequencer owns the array.

Behaviour:
- Clock and reset: one clock, forever_cpuclk; reset cpurst_b is asynchronous, active low.
- Reset values: Q=0, QVLD=0, init_busy=1, FSM=INIT, init address counter=0.
- FSM states:
  - INIT: one write per cycle of INIT_VALUE to counter address, all groups enabled. Counter increments each cycle. At counter == 2**ADDR_WIDTH-1 the last write is issued, then go to IDLE next cycle; the counter wraps to 0. init_busy deasserts in the first IDLE cycle. Init takes exactly 2**ADDR_WIDTH cycles.
  - IDLE: external access accepted when CEN=0.
    - Write (GWEN=0): groups with WEN[g]=0 are updated; others keep their value. Q and QVLD are unaffected.
    - Read (GWEN=1): Q is updated with mem[A] and QVLD pulses OUT_LATENCY cycles after the request edge.
    - Back-to-back reads every cycle are supported at both latencies.
- External accesses in INIT are dropped silently: no write, no QVLD. Callers must gate on init_busy.
- init_req in IDLE moves to INIT next cycle with counter=0. If CEN=0 in the same cycle, init wins and the access is dropped. init_req while in INIT is ignored (no restart).
- Reads in the OUT_LATENCY pipeline when INIT starts still complete and pulse QVLD; data is the pre-init contents.
- Reset asserted mid-init or mid-read: everything returns to reset values and init restarts from address 0. In-flight read data is discarded.
- CEN=0 with GWEN=0 and WEN all ones is a legal no-op write.

Optional Feature:
CT_SPSRAM_PARITY_EN.
- Defined:
  - Storage widens by WE_WIDTH bits, one even-parity bit per group, written with its group.
  - Adds output port parity_err (1 bit, reset 0). It pulses with QVLD when any group's stored parity mismatches.
  - Q is still returned unmodified.
  - Init writes parity consistent with INIT_VALUE.
- Undefined: no parity storage and no parity_err port; timing and behaviour otherwise identical.

Decomposition:
- Package ct_spsram_pkg holds:
  - FSM state enum {INIT, IDLE};
  - a group-width function DATA_WIDTH/WE_WIDTH;
  - a parity-per-group function.
- Sub-module ct_spsram_init_seq: FSM, address counter and the access mux (init vs external).
- The top instantiates ct_spsram_init_seq plus tc_sram (Latency 1). For OUT_LATENCY=2 it adds one output register stage and the QVLD pipeline.

Test Plan:
1. Reset release, ADDR_WIDTH=8 -> init_busy high for exactly 256 cycles. Then read addresses 0, 127 and 255 -> Q==INIT_VALUE with QVLD 1 (or 2) cycles after each request.
2. After init, write A=5, D=all-ones, WEN alternating groups 0/1 -> read A=5 returns ones only in groups with WEN=0, rest INIT_VALUE.
3. Write during INIT (CEN=0, GWEN=0, A=3, D=0xAB..) -> after init, A=3 reads INIT_VALUE and no QVLD was seen during init.
4. OUT_LATENCY=2, reads to A=0..9 on consecutive cycles -> 10 consecutive QVLD pulses starting cycle 2 with matching data. Q holds the last value afterwards.
5. init_req coincident with a write to A=7 -> write dropped, init_busy next cycle for 256 cycles, A=7 reads INIT_VALUE. cpurst_b pulsed at counter=100 -> init restarts, total 256 cycles from release.
6. CT_SPSRAM_PARITY_EN: backdoor-flip one data bit at A=9 -> read A=9 gives parity_err=1 coincident with QVLD. A clean read at A=8 gives parity_err=0.
